// File: rtl/io_bus_initiator_pkg.sv
// Shared definitions for the I/O bus initiator and the bus-master side.
package io_bus_initiator_pkg;

  localparam int unsigned DefaultTimeout = 255;
  localparam int unsigned DefaultRecov   = 2;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StAct,
    StDone,
    StRecov
  } ioState_e;

  // Number of bits needed to hold values 0..maxVal (at least one).
  function automatic int unsigned cntWidth(input int unsigned maxVal);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) <= 64'(maxVal)) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back stages; both cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/io_bus_initiator.sv
// Issues one I/O cycle per CPU request to the bus master and terminates the
// CPU cycle with an ACK, or with a bus error when the master never answers.
module io_bus_initiator
  import io_bus_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout,
  parameter int unsigned RECOV   = DefaultRecov
) (
  input  logic CLK,
  input  logic RST,
  input  logic CPUREQ,
  input  logic CPUWE,
  input  logic CPULDS,
  input  logic CPUUDS,
  input  logic IOACT,
  output logic IOREQ,
  output logic IOWE,
  output logic IOLDS,
  output logic IOUDS,
  output logic nADLEEN,
  output logic CPUACK,
  output logic CPUBERR,
  output logic IOBUSY
);

  localparam int unsigned TimerW    = cntWidth(TIMEOUT);
  localparam int unsigned RecovLast = (RECOV == 0) ? 0 : RECOV - 1;
  localparam int unsigned RecovW    = cntWidth(RecovLast);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT);
  localparam logic [RecovW-1:0] RecovEnd = RecovW'(RecovLast);

  ioState_e          state, stateNext;
  logic [TimerW-1:0] timer, timerNext, timerInc;
  logic [RecovW-1:0] recovCnt, recovCntNext;
  logic              timeoutHit;
  logic              arm, armNext;
  logic              ioActS;
  logic              ioReqNext, ioWeNext, ioLdsNext, ioUdsNext;
  logic              nAdleenNext, cpuAckNext, cpuBerrNext, ioBusyNext;

  sync2 uIoActSync (
    .clk(CLK),
    .rst(RST),
    .d  (IOACT),
    .q  (ioActS)
  );

  // Saturating timer step; timeout fires on the cycle the timer reaches TIMEOUT.
  always_comb begin
    timerInc   = (timer == TimerMax) ? timer : timer + TimerW'(1);
    timeoutHit = (timerInc == TimerMax);
  end

  // Next-state and next-output decode.
  always_comb begin
    stateNext    = state;
    timerNext    = timer;
    recovCntNext = recovCnt;
    armNext      = arm;
    ioReqNext    = IOREQ;
    ioWeNext     = IOWE;
    ioLdsNext    = IOLDS;
    ioUdsNext    = IOUDS;
    cpuAckNext   = 1'b0;
    cpuBerrNext  = 1'b0;

    // A low request re-arms; clears below take priority on the same edge.
    if (!CPUREQ) begin
      armNext = 1'b1;
    end

    case (state)
      StIdle: begin
        if (CPUREQ && arm) begin
          ioWeNext  = CPUWE;
          ioLdsNext = CPULDS;
          ioUdsNext = CPUUDS;
          ioReqNext = 1'b1;
          timerNext = '0;
          stateNext = StReq;
        end
      end
      StReq: begin
        timerNext = timerInc;
        if (timeoutHit) begin
          ioReqNext    = 1'b0;
          cpuBerrNext  = 1'b1;
          armNext      = 1'b0;
          recovCntNext = '0;
          stateNext    = StRecov;
        end else if (ioActS) begin
          ioReqNext = 1'b0;
          stateNext = StAct;
        end
      end
      StAct: begin
        timerNext = timerInc;
        if (timeoutHit) begin
          ioReqNext    = 1'b0;
          cpuBerrNext  = 1'b1;
          armNext      = 1'b0;
          recovCntNext = '0;
          stateNext    = StRecov;
        end else if (!ioActS) begin
          cpuAckNext = 1'b1;
          armNext    = 1'b0;
          stateNext  = StDone;
        end
      end
      StDone: begin
        recovCntNext = '0;
        stateNext    = StRecov;
      end
      StRecov: begin
        if (recovCnt == RecovEnd) begin
          stateNext = StIdle;
        end else begin
          recovCntNext = recovCnt + RecovW'(1);
        end
      end
      default: begin
        stateNext = StIdle;
      end
    endcase

    nAdleenNext = !((stateNext == StReq) || (stateNext == StAct));
    ioBusyNext  = (stateNext != StIdle);
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= StIdle;
      timer    <= '0;
      recovCnt <= '0;
      arm      <= 1'b1;
      IOREQ    <= 1'b0;
      IOWE     <= 1'b0;
      IOLDS    <= 1'b0;
      IOUDS    <= 1'b0;
      nADLEEN  <= 1'b1;
      CPUACK   <= 1'b0;
      CPUBERR  <= 1'b0;
      IOBUSY   <= 1'b0;
    end else begin
      state    <= stateNext;
      timer    <= timerNext;
      recovCnt <= recovCntNext;
      arm      <= armNext;
      IOREQ    <= ioReqNext;
      IOWE     <= ioWeNext;
      IOLDS    <= ioLdsNext;
      IOUDS    <= ioUdsNext;
      nADLEEN  <= nAdleenNext;
      CPUACK   <= cpuAckNext;
      CPUBERR  <= cpuBerrNext;
      IOBUSY   <= ioBusyNext;
    end
  end

endmodule

// File: tb/tb_io_bus_initiator.sv
// Directed bench for io_bus_initiator (TIMEOUT=255, RECOV=2).
module tb_io_bus_initiator;

  logic CLK = 1'b0;
  logic RST, CPUREQ, CPUWE, CPULDS, CPUUDS, IOACT;
  logic IOREQ, IOWE, IOLDS, IOUDS, nADLEEN, CPUACK, CPUBERR, IOBUSY;

  int checks = 0;
  int errors = 0;

  io_bus_initiator #(.TIMEOUT(255), .RECOV(2)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .CPUREQ (CPUREQ),
    .CPUWE  (CPUWE),
    .CPULDS (CPULDS),
    .CPUUDS (CPUUDS),
    .IOACT  (IOACT),
    .IOREQ  (IOREQ),
    .IOWE   (IOWE),
    .IOLDS  (IOLDS),
    .IOUDS  (IOUDS),
    .nADLEEN(nADLEEN),
    .CPUACK (CPUACK),
    .CPUBERR(CPUBERR),
    .IOBUSY (IOBUSY)
  );

  always #5 CLK = ~CLK;

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulseIoAct(input int highTicks);
    IOACT = 1'b1;
    repeat (highTicks) tick();
    IOACT = 1'b0;
  endtask

  // Returns the tick index of the first ACK/BERR, or -1 if none within 20.
  task automatic waitTerm(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (CPUACK === 1'b1 || CPUBERR === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] got;
    RST = 1'b1; CPUREQ = 1'b1; CPUWE = 1'b1; CPULDS = 1'b1; CPUUDS = 1'b1; IOACT = 1'b1;
    tick(); tick();
    got = {IOREQ, IOWE, IOLDS, IOUDS, nADLEEN, CPUACK, CPUBERR, IOBUSY};
    checks++;
    if (got !== 8'b0000_1000) begin
      errors++;
      $display("FAIL reset_values: got %b expected %b", got, 8'b0000_1000);
    end
    CPUREQ = 1'b0; IOACT = 1'b0; RST = 1'b0;
    tick(); tick();
    got = {IOREQ, IOWE, IOLDS, IOUDS, nADLEEN, CPUACK, CPUBERR, IOBUSY};
    checks++;
    if (got !== 8'b0000_1000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected %b", got, 8'b0000_1000);
    end
  endtask

  task automatic test_read();
    logic [5:0] got;
    int n, acks, berrs;
    CPUREQ = 1'b1; CPUWE = 1'b0; CPULDS = 1'b1; CPUUDS = 1'b0;
    tick();
    got = {IOREQ, IOWE, IOLDS, IOUDS, nADLEEN, IOBUSY};
    checks++;
    if (got !== 6'b101001) begin
      errors++;
      $display("FAIL read_launch: got %b expected %b", got, 6'b101001);
    end
    repeat (4) tick();
    IOACT = 1'b1;
    n = 0;
    while (IOREQ === 1'b1 && n < 6) begin
      tick();
      n++;
    end
    checks++;
    if (n < 1 || n > 3) begin
      errors++;
      $display("FAIL read_ioreq_drop: got %0d edges expected 1..3", n);
    end
    checks++;
    if (nADLEEN !== 1'b0) begin
      errors++;
      $display("FAIL read_adlee_in_act: got %b expected 0", nADLEEN);
    end
    repeat (12 - n) tick();
    IOACT = 1'b0;
    acks = 0; berrs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (CPUACK === 1'b1) begin
        acks++;
        CPUREQ = 1'b0;
      end
      if (CPUBERR === 1'b1) berrs++;
    end
    checks++;
    if (acks != 1 || berrs != 0) begin
      errors++;
      $display("FAIL read_ack_count: got ack=%0d berr=%0d expected ack=1 berr=0", acks, berrs);
    end
    got = {IOREQ, IOWE, IOLDS, IOUDS, nADLEEN, IOBUSY};
    checks++;
    if (got !== 6'b001010) begin
      errors++;
      $display("FAIL read_idle_after: got %b expected %b", got, 6'b001010);
    end
  endtask

  task automatic test_stuck_master();
    int n, acks;
    logic [2:0] got;
    CPUREQ = 1'b1; CPUWE = 1'b1; CPULDS = 1'b0; CPUUDS = 1'b1; IOACT = 1'b0;
    tick();
    n = -1; acks = 0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (CPUACK === 1'b1) acks++;
      if (CPUBERR === 1'b1) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != 255) begin
      errors++;
      $display("FAIL stuck_berr_time: got %0d edges expected 255", n);
    end
    got = {IOREQ, CPUACK, CPUBERR};
    checks++;
    if (got !== 3'b001 || acks != 0) begin
      errors++;
      $display("FAIL stuck_berr_outputs: got %b acks=%0d expected 001 acks=0", got, acks);
    end
    CPUREQ = 1'b0;
    tick();
    checks++;
    if (CPUBERR !== 1'b0) begin
      errors++;
      $display("FAIL stuck_berr_pulse: got %b expected 0", CPUBERR);
    end
    repeat (4) tick();
    checks++;
    if (IOBUSY !== 1'b0 || nADLEEN !== 1'b1) begin
      errors++;
      $display("FAIL stuck_recover: got busy=%b nadlee=%b expected 0 1", IOBUSY, nADLEEN);
    end
  endtask

  task automatic test_timeout_tie();
    int n, acks;
    logic reqAt254;
    CPUREQ = 1'b1; CPUWE = 1'b0; CPULDS = 1'b1; CPUUDS = 1'b1; IOACT = 1'b0;
    tick();
    n = -1; reqAt254 = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 252) IOACT = 1'b1;
      if (i == 254) reqAt254 = IOREQ;
      if (CPUBERR === 1'b1 || CPUACK === 1'b1 || IOREQ !== 1'b1) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != 255 || CPUBERR !== 1'b1 || reqAt254 !== 1'b1) begin
      errors++;
      $display("FAIL tie_timeout_wins: got edge=%0d berr=%b req254=%b expected 255 1 1",
               n, CPUBERR, reqAt254);
    end
    CPUREQ = 1'b0;
    acks = 0;
    repeat (6) begin
      tick();
      if (CPUACK === 1'b1) acks++;
    end
    IOACT = 1'b0;
    repeat (3) tick();
    checks++;
    if (acks != 0 || IOBUSY !== 1'b0) begin
      errors++;
      $display("FAIL tie_no_ack: got acks=%0d busy=%b expected 0 0", acks, IOBUSY);
    end
  endtask

  task automatic test_held_request();
    int n, bad;
    logic [3:0] got;
    CPUREQ = 1'b1; CPUWE = 1'b1; CPULDS = 1'b0; CPUUDS = 1'b1;
    tick();
    pulseIoAct(6);
    waitTerm(n);
    checks++;
    if (n < 0 || CPUACK !== 1'b1) begin
      errors++;
      $display("FAIL held_first_ack: got edge=%0d ack=%b expected ack=1", n, CPUACK);
    end
    bad = 0;
    repeat (4) begin
      tick();
      if (IOREQ !== 1'b0 || CPUACK !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL held_no_relaunch: got %0d bad cycles expected 0", bad);
    end
    CPUREQ = 1'b0; CPUWE = 1'b0; CPULDS = 1'b1; CPUUDS = 1'b1;
    tick();
    checks++;
    if (IOREQ !== 1'b0) begin
      errors++;
      $display("FAIL held_low_cycle: got %b expected 0", IOREQ);
    end
    CPUREQ = 1'b1;
    tick();
    got = {IOREQ, IOWE, IOLDS, IOUDS};
    checks++;
    if (got !== 4'b1011) begin
      errors++;
      $display("FAIL held_relaunch: got %b expected %b", got, 4'b1011);
    end
    pulseIoAct(6);
    waitTerm(n);
    CPUREQ = 1'b0;
    checks++;
    if (CPUACK !== 1'b1) begin
      errors++;
      $display("FAIL held_second_ack: got %b expected 1", CPUACK);
    end
    repeat (4) tick();
  endtask

  task automatic test_abort_attempt();
    int n, acks;
    CPUREQ = 1'b1; CPUWE = 1'b0; CPULDS = 1'b1; CPUUDS = 1'b1;
    tick();
    CPUREQ = 1'b0;
    tick(); tick();
    checks++;
    if (IOREQ !== 1'b1 || IOBUSY !== 1'b1) begin
      errors++;
      $display("FAIL abort_still_req: got req=%b busy=%b expected 1 1", IOREQ, IOBUSY);
    end
    pulseIoAct(6);
    waitTerm(n);
    checks++;
    if (CPUACK !== 1'b1 || CPUBERR !== 1'b0) begin
      errors++;
      $display("FAIL abort_completes: got ack=%b berr=%b expected 1 0", CPUACK, CPUBERR);
    end
    acks = 0;
    repeat (6) begin
      tick();
      if (CPUACK === 1'b1 || IOREQ === 1'b1) acks++;
    end
    checks++;
    if (acks != 0 || IOBUSY !== 1'b0) begin
      errors++;
      $display("FAIL abort_single_ack: got extra=%0d busy=%b expected 0 0", acks, IOBUSY);
    end
  endtask

  task automatic test_reset_in_act();
    logic [7:0] got;
    int term;
    CPUREQ = 1'b1; CPUWE = 1'b1; CPULDS = 1'b1; CPUUDS = 1'b0;
    tick();
    IOACT = 1'b1;
    repeat (4) tick();
    checks++;
    if (IOREQ !== 1'b0 || nADLEEN !== 1'b0 || IOBUSY !== 1'b1) begin
      errors++;
      $display("FAIL rst_act_reached: got req=%b nadlee=%b busy=%b expected 0 0 1",
               IOREQ, nADLEEN, IOBUSY);
    end
    RST = 1'b1;
    tick();
    got = {IOREQ, IOWE, IOLDS, IOUDS, nADLEEN, CPUACK, CPUBERR, IOBUSY};
    checks++;
    if (got !== 8'b0000_1000) begin
      errors++;
      $display("FAIL rst_act_values: got %b expected %b", got, 8'b0000_1000);
    end
    RST = 1'b0; IOACT = 1'b0; CPUREQ = 1'b0;
    term = 0;
    repeat (8) begin
      tick();
      if (CPUACK !== 1'b0 || CPUBERR !== 1'b0 || IOBUSY !== 1'b0) term++;
    end
    checks++;
    if (term != 0) begin
      errors++;
      $display("FAIL rst_act_quiet: got %0d active cycles expected 0", term);
    end
  endtask

  task automatic test_back_to_back();
    int n, rise;
    logic [2:0] held, got;
    CPUREQ = 1'b1; CPUWE = 1'b1; CPULDS = 1'b1; CPUUDS = 1'b1;
    tick();
    pulseIoAct(6);
    waitTerm(n);
    checks++;
    if (CPUACK !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_ack: got %b expected 1", CPUACK);
    end
    CPUREQ = 1'b0;
    tick();
    CPUREQ = 1'b1; CPUWE = 1'b1; CPULDS = 1'b0; CPUUDS = 1'b1;
    rise = -1; held = 3'b000;
    for (int i = 2; i <= 10; i++) begin
      tick();
      if (i == 2) held = {IOWE, IOLDS, IOUDS};
      if (IOREQ === 1'b1) begin
        rise = i;
        break;
      end
    end
    checks++;
    if (held !== 3'b111) begin
      errors++;
      $display("FAIL b2b_qual_held: got %b expected %b", held, 3'b111);
    end
    checks++;
    if (rise < 3) begin
      errors++;
      $display("FAIL b2b_recov_gap: got IOREQ at edge %0d after DONE expected >=3", rise);
    end
    got = {IOWE, IOLDS, IOUDS};
    checks++;
    if (got !== 3'b101) begin
      errors++;
      $display("FAIL b2b_second_qual: got %b expected %b", got, 3'b101);
    end
    pulseIoAct(6);
    waitTerm(n);
    CPUREQ = 1'b0;
    checks++;
    if (CPUACK !== 1'b1 || CPUBERR !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_ack: got ack=%b berr=%b expected 1 0", CPUACK, CPUBERR);
    end
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_stuck_master();
    test_timeout_tie();
    test_held_request();
    test_abort_attempt();
    test_reset_in_act();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 ns");
    $fatal(1);
  end

endmodule
